alu_share_arbiter: RTL and testbench

//  Shares one 4-bit ALU (add/sub/or/xor) between two requesters. Each requester

---
 rtl/alu_share_pkg.sv | 17 +
 rtl/alu_core.sv | 39 +++
 rtl/alu_share_arbiter.sv | 111 +++++++++++
 tb/tb_alu_share_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
// rtl/alu_share_pkg.sv - shared opcodes, FSM states and requester count for the ALU share arbiter
package alu_share_pkg;

    localparam int NUM_REQ = 2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational add/sub/or/xor datapath with carry/borrow out
module alu_core
    import alu_share_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // One extra bit on each side: bit WIDTH is carry for ADD and borrow (A<B) for SUB.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result = w_sum[WIDTH-1:0];
                o_carry  = w_sum[WIDTH];
            end
            OP_SUB: begin
                o_result = w_diff[WIDTH-1:0];
                o_carry  = w_diff[WIDTH];
            end
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one registered ALU between two requesters
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ*3-1:0]       req_op,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_id,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       rsp_carry
);

    state_t           r_state;
    logic             r_rr_ptr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_id;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_carry;

    logic             w_any;
    logic             w_grant;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [2:0]       w_sel_op;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;

    // Pointer owner wins if it is asking; otherwise the other requester gets the slot.
    assign w_any    = |req_valid;
    assign w_grant  = req_valid[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
    assign w_sel_a  = w_grant ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign w_sel_b  = w_grant ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
    assign w_sel_op = w_grant ? req_op[5:3] : req_op[2:0];

    always_comb begin
        req_ready = '0;
        if (r_state == IDLE && w_any) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .o_result (w_result),
        .o_carry  (w_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_op    <= w_sel_op;
                        r_id    <= w_grant;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_data  <= w_result;
                    r_rsp_carry <= w_carry;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rr_ptr    <= ~r_rsp_id;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_carry = r_rsp_carry;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter against an arithmetic reference
module tb_alu_share_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [5:0] req_op;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [3:0] rsp_data;
    logic       rsp_carry;

    int   n_checks = 0;
    int   n_errors = 0;
    logic model_ptr;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry)
    );

    // Reference result as {carry, data}, from plain integer arithmetic.
    function automatic logic [4:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int ia = int'(a);
        int ib = int'(b);
        int r;
        case (int'(op))
            0:       r = ia + ib;
            1:       r = ((ia < ib) ? 16 : 0) + ((ia - ib + 16) % 16);
            2:       r = ia | ib;
            3:       r = ia ^ ib;
            default: r = 0;
        endcase
        return r[4:0];
    endfunction

    task automatic drive_req(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        if (id) begin
            req_a[7:4] = a; req_b[7:4] = b; req_op[5:3] = op;
        end else begin
            req_a[3:0] = a; req_b[3:0] = b; req_op[2:0] = op;
        end
    endtask

    // Single request from one requester; reports wait for grant, grant-to-valid latency and response.
    task automatic xact(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        output int wait_c, output int lat, output logic rid, output logic [3:0] rd, output logic rc);
        wait_c = 0;
        @(negedge clk);
        drive_req(id, a, b, op);
        req_valid[id] = 1'b1;
        #1;
        while (req_ready[id] !== 1'b1 && wait_c < 10) begin
            @(negedge clk); wait_c++; #1;
        end
        @(negedge clk);
        req_valid[id] = 1'b0;
        lat = 1;
        #1;
        while (rsp_valid !== 1'b1 && lat < 10) begin
            @(negedge clk); lat++; #1;
        end
        rid = rsp_id; rd = rsp_data; rc = rsp_carry;
        @(negedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (req_ready !== 2'b00) begin n_errors++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_checks++; if ({rsp_id, rsp_carry, rsp_data} !== 6'd0) begin n_errors++; $display("FAIL reset_rsp_fields: got %b expected 000000", {rsp_id, rsp_carry, rsp_data}); end
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (req_ready !== 2'b00 || rsp_valid !== 1'b0) begin n_errors++; $display("FAIL idle_quiet: got ready=%b valid=%b expected 00/0", req_ready, rsp_valid); end
    endtask

    task automatic test_single;
        int w, l; logic rid, rc; logic [3:0] rd;
        rsp_ready = 1'b1;
        xact(1'b0, 4'd3, 4'd5, 3'd0, w, l, rid, rd, rc);
        n_checks++; if (w !== 0) begin n_errors++; $display("FAIL single_wait: got %0d expected 0", w); end
        n_checks++; if (l !== 2) begin n_errors++; $display("FAIL single_latency: got %0d expected 2", l); end
        n_checks++; if (rid !== 1'b0) begin n_errors++; $display("FAIL single_id: got %b expected 0", rid); end
        n_checks++; if (rd !== 4'd8) begin n_errors++; $display("FAIL single_data: got %0d expected 8", rd); end
        n_checks++; if (rc !== 1'b0) begin n_errors++; $display("FAIL single_carry: got %b expected 0", rc); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL single_valid_drop: got %b expected 0", rsp_valid); end
        model_ptr = 1'b1;
    endtask

    task automatic test_ops;
        logic [3:0] ta [5] = '{4'd9, 4'd2, 4'd12, 4'd12, 4'd3};
        logic [3:0] tb [5] = '{4'd9, 4'd5, 4'd10, 4'd10, 4'd4};
        logic [2:0] to [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
        logic [3:0] ed [5] = '{4'd2, 4'd13, 4'd14, 4'd6, 4'd0};
        logic       ec [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int w, l; logic rid, rc; logic [3:0] rd;
        for (int i = 0; i < 5; i++) begin
            xact(i[0], ta[i], tb[i], to[i], w, l, rid, rd, rc);
            n_checks++; if (rid !== i[0]) begin n_errors++; $display("FAIL ops_id[%0d]: got %b expected %b", i, rid, i[0]); end
            n_checks++; if (rd !== ed[i]) begin n_errors++; $display("FAIL ops_data[%0d]: got %0d expected %0d", i, rd, ed[i]); end
            n_checks++; if (rc !== ec[i]) begin n_errors++; $display("FAIL ops_carry[%0d]: got %b expected %b", i, rc, ec[i]); end
            model_ptr = ~i[0];
        end
    endtask

    task automatic test_contention;
        logic [5:0] exp_q [$];
        logic [5:0] e;
        logic [4:0] r;
        logic       g;
        int         last_acc = -1;
        int         n_grants = 0;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(negedge clk);
            req_a = 8'($urandom); req_b = 8'($urandom); req_op = 6'($urandom);
            req_valid = (cyc < 30) ? 2'b11 : 2'b00;
            #1;
            n_checks++; if (req_ready === 2'b11) begin n_errors++; $display("FAIL cont_onehot: got %b expected at most one bit", req_ready); end
            if (req_ready !== 2'b00) begin
                g = req_ready[1];
                n_checks++; if (g !== model_ptr) begin n_errors++; $display("FAIL cont_grant: got %b expected %b", g, model_ptr); end
                if (last_acc >= 0) begin
                    n_checks++; if (cyc - last_acc !== 3) begin n_errors++; $display("FAIL cont_spacing: got %0d expected 3", cyc - last_acc); end
                end
                last_acc = cyc;
                n_grants++;
                r = g ? ref_alu(req_a[7:4], req_b[7:4], req_op[5:3]) : ref_alu(req_a[3:0], req_b[3:0], req_op[2:0]);
                exp_q.push_back({g, r});
            end
            if (rsp_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL cont_unexpected_rsp: got id=%b data=%0d expected no response", rsp_id, rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_id, rsp_carry, rsp_data} !== e) begin n_errors++; $display("FAIL cont_rsp: got %b expected %b", {rsp_id, rsp_carry, rsp_data}, e); end
                    model_ptr = ~e[5];
                end
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL cont_drain: got %0d outstanding expected 0", exp_q.size()); end
        n_checks++; if (n_grants != 10) begin n_errors++; $display("FAIL cont_grant_count: got %0d expected 10", n_grants); end
    endtask

    task automatic test_backpressure;
        logic [4:0] e0 = ref_alu(4'd7, 4'd12, 3'd0);
        logic [4:0] e1 = ref_alu(4'd1, 4'd1, 3'd0);
        int n;
        rsp_ready = 1'b0;
        @(negedge clk);
        drive_req(1'b0, 4'd7, 4'd12, 3'd0);
        drive_req(1'b1, 4'd1, 4'd1, 3'd0);
        req_valid = 2'b01;
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL bp_accept: got %b expected 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        n_checks++; if (req_ready !== 2'b00) begin n_errors++; $display("FAIL bp_exec_ready: got %b expected 00", req_ready); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            n_checks++; if (rsp_valid !== 1'b1 || req_ready !== 2'b00) begin n_errors++; $display("FAIL bp_hold[%0d]: got valid=%b ready=%b expected 1/00", k, rsp_valid, req_ready); end
            n_checks++; if ({rsp_id, rsp_carry, rsp_data} !== {1'b0, e0}) begin n_errors++; $display("FAIL bp_stable[%0d]: got %b expected %b", k, {rsp_id, rsp_carry, rsp_data}, {1'b0, e0}); end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL bp_release_valid: got %b expected 1", rsp_valid); end
        @(negedge clk); #1;
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin n_errors++; $display("FAIL bp_next_grant: got valid=%b ready=%b expected 0/10", rsp_valid, req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        n = 0; #1;
        while (rsp_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; #1; end
        n_checks++; if ({rsp_valid, rsp_id, rsp_carry, rsp_data} !== {2'b11, e1}) begin n_errors++; $display("FAIL bp_second_rsp: got %b expected %b", {rsp_valid, rsp_id, rsp_carry, rsp_data}, {2'b11, e1}); end
        @(negedge clk); #1;
        model_ptr = 1'b0;
    endtask

    task automatic test_reset_mid;
        int w, l, n; logic rid, rc, seen; logic [3:0] rd;
        logic [4:0] e;
        rsp_ready = 1'b1;
        xact(1'b0, 4'd6, 4'd7, 3'd0, w, l, rid, rd, rc);
        n_checks++; if ({rid, rc, rd} !== 6'd13) begin n_errors++; $display("FAIL rmid_pre: got %b expected 001101", {rid, rc, rd}); end
        @(negedge clk);
        drive_req(1'b1, 4'd15, 4'd15, 3'd0);
        req_valid = 2'b10;
        #1;
        n_checks++; if (req_ready !== 2'b10) begin n_errors++; $display("FAIL rmid_accept: got %b expected 10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b1;
        #1;
        n_checks++; if ({rsp_valid, rsp_id, rsp_carry, rsp_data, req_ready} !== 9'd0) begin n_errors++; $display("FAIL rmid_async: got %b expected 000000000", {rsp_valid, rsp_id, rsp_carry, rsp_data, req_ready}); end
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(negedge clk); #1; if (rsp_valid !== 1'b0) seen = 1'b1; end
        n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL rmid_discard: got response expected none"); end
        @(negedge clk);
        drive_req(1'b0, 4'd5, 4'd3, 3'd1);
        req_valid = 2'b11;
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL rmid_ptr: got %b expected 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        n = 0; #1;
        while (rsp_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; #1; end
        e = ref_alu(4'd5, 4'd3, 3'd1);
        n_checks++; if ({rsp_valid, rsp_id, rsp_carry, rsp_data} !== {2'b10, e}) begin n_errors++; $display("FAIL rmid_ptr_rsp: got %b expected %b", {rsp_valid, rsp_id, rsp_carry, rsp_data}, {2'b10, e}); end
        @(negedge clk); #1;
        xact(1'b1, 4'd15, 4'd15, 3'd0, w, l, rid, rd, rc);
        n_checks++; if (w !== 0 || l !== 2) begin n_errors++; $display("FAIL rmid_req1_timing: got wait=%0d lat=%0d expected 0/2", w, l); end
        n_checks++; if ({rid, rc, rd} !== 6'b111110) begin n_errors++; $display("FAIL rmid_req1_rsp: got %b expected 111110", {rid, rc, rd}); end
    endtask

    task automatic test_lone;
        int w, l; logic rid, rc; logic [3:0] rd, a, b; logic [2:0] op; logic [4:0] e;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 4'($urandom); b = 4'($urandom); op = 3'($urandom_range(3, 0));
            e = ref_alu(a, b, op);
            xact(1'b1, a, b, op, w, l, rid, rd, rc);
            n_checks++; if (w !== 0 || rid !== 1'b1) begin n_errors++; $display("FAIL lone_grant[%0d]: got wait=%0d id=%b expected 0/1", i, w, rid); end
            n_checks++; if ({rc, rd} !== e) begin n_errors++; $display("FAIL lone_rsp[%0d]: got %b expected %b", i, {rc, rd}, e); end
        end
    endtask

    task automatic test_random;
        int w, l; logic id, rid, rc; logic [3:0] rd, a, b; logic [2:0] op; logic [4:0] e;
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            id = 1'($urandom); a = 4'($urandom); b = 4'($urandom); op = 3'($urandom);
            e = ref_alu(a, b, op);
            xact(id, a, b, op, w, l, rid, rd, rc);
            n_checks++; if (l !== 2 || rid !== id) begin n_errors++; $display("FAIL rand_meta[%0d]: got lat=%0d id=%b expected 2/%b", i, l, rid, id); end
            n_checks++; if ({rc, rd} !== e) begin n_errors++; $display("FAIL rand_rsp[%0d]: a=%0d b=%0d op=%0d got %b expected %b", i, a, b, op, {rc, rd}, e); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single;
        test_ops;
        test_contention;
        test_backpressure;
        test_reset_mid;
        test_lone;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
